// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle carrying a control field and a payload between
// two pipeline stages.
interface pipe_stage_skid_if #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 64
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a two-entry skid buffer: registered ready,
// global stall freeze, flush-to-bubble and in-order delivery.
module pipe_stage_skid #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                cpu_stall_i,
  input  logic                flush_i,
  pipe_stage_skid_if.slave    up,
  pipe_stage_skid_if.master   dn,
  output logic [1:0]          occupancy_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e            state_r;
  state_e            state_nxt_s;
  logic [CTRL_W-1:0] main_ctrl_r;
  logic [CTRL_W-1:0] main_ctrl_nxt_s;
  logic [DATA_W-1:0] main_data_r;
  logic [DATA_W-1:0] main_data_nxt_s;
  logic [CTRL_W-1:0] skid_ctrl_r;
  logic [CTRL_W-1:0] skid_ctrl_nxt_s;
  logic [DATA_W-1:0] skid_data_r;
  logic [DATA_W-1:0] skid_data_nxt_s;
  logic              in_ready_r;
  logic              out_valid_r;
  logic [1:0]        occupancy_r;
  logic              accept_s;
  logic              take_s;

  // Qualified handshake events; stall and flush suppress both.
  always_comb begin
    accept_s = up.valid & in_ready_r & start_i & ~cpu_stall_i & ~flush_i;
    take_s   = out_valid_r & dn.ready & ~cpu_stall_i & ~flush_i;
  end

  // Next-state and next-contents decode; flush beats stall beats handshake.
  always_comb begin
    state_nxt_s     = state_r;
    main_ctrl_nxt_s = main_ctrl_r;
    main_data_nxt_s = main_data_r;
    skid_ctrl_nxt_s = skid_ctrl_r;
    skid_data_nxt_s = skid_data_r;
    if (flush_i) begin
      // Bubble: control cleared, payload left as is.
      state_nxt_s     = ST_EMPTY;
      main_ctrl_nxt_s = {CTRL_W{1'b0}};
      skid_ctrl_nxt_s = {CTRL_W{1'b0}};
    end else if (cpu_stall_i) begin
      state_nxt_s = state_r;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_nxt_s     = ST_ONE;
            main_ctrl_nxt_s = up.ctrl;
            main_data_nxt_s = up.data;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && take_s) begin
            state_nxt_s     = ST_ONE;
            main_ctrl_nxt_s = up.ctrl;
            main_data_nxt_s = up.data;
          end else if (accept_s) begin
            state_nxt_s     = ST_FULL;
            skid_ctrl_nxt_s = up.ctrl;
            skid_data_nxt_s = up.data;
          end else if (take_s) begin
            state_nxt_s     = ST_EMPTY;
            main_ctrl_nxt_s = {CTRL_W{1'b0}};
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a take can happen.
          if (take_s) begin
            state_nxt_s     = ST_ONE;
            main_ctrl_nxt_s = skid_ctrl_r;
            main_data_nxt_s = skid_data_r;
            skid_ctrl_nxt_s = {CTRL_W{1'b0}};
          end else begin
            state_nxt_s = ST_FULL;
          end
        end
        default: begin
          state_nxt_s     = ST_EMPTY;
          main_ctrl_nxt_s = {CTRL_W{1'b0}};
          skid_ctrl_nxt_s = {CTRL_W{1'b0}};
        end
      endcase
    end
  end

  // State, storage and registered status flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= ST_EMPTY;
      main_ctrl_r <= {CTRL_W{1'b0}};
      main_data_r <= {DATA_W{1'b0}};
      skid_ctrl_r <= {CTRL_W{1'b0}};
      skid_data_r <= {DATA_W{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      occupancy_r <= 2'd0;
    end else begin
      state_r     <= state_nxt_s;
      main_ctrl_r <= main_ctrl_nxt_s;
      main_data_r <= main_data_nxt_s;
      skid_ctrl_r <= skid_ctrl_nxt_s;
      skid_data_r <= skid_data_nxt_s;
      in_ready_r  <= (state_nxt_s != ST_FULL);
      out_valid_r <= (state_nxt_s != ST_EMPTY);
      occupancy_r <= state_nxt_s;
    end
  end

  assign up.ready    = in_ready_r;
  assign dn.valid    = out_valid_r;
  assign dn.ctrl     = main_ctrl_r;
  assign dn.data     = main_data_r;
  assign occupancy_o = occupancy_r;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid with hand-computed expected values.
module tb_pipe_stage_skid;

  localparam int DATA_W = 64;
  localparam int CTRL_W = 8;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic       cpu_stall_i;
  logic       flush_i;
  logic [1:0] occupancy_o;

  int n_checks = 0;
  int n_errors = 0;

  pipe_stage_skid_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) up_if ();
  pipe_stage_skid_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dn_if ();

  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .cpu_stall_i (cpu_stall_i),
    .flush_i     (flush_i),
    .up          (up_if),
    .dn          (dn_if),
    .occupancy_o (occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] c,
                         input logic [63:0] d, input logic [1:0] occ, input logic rdy);
    chk({tag, ".valid"}, {63'd0, dn_if.valid}, {63'd0, v});
    chk({tag, ".ctrl"},  {56'd0, dn_if.ctrl},  {56'd0, c});
    chk({tag, ".data"},  dn_if.data, d);
    chk({tag, ".occ"},   {62'd0, occupancy_o}, {62'd0, occ});
    chk({tag, ".ready"}, {63'd0, up_if.ready}, {63'd0, rdy});
  endtask

  task automatic push(input logic [7:0] c, input logic [63:0] d);
    up_if.valid = 1'b1;
    up_if.ctrl  = c;
    up_if.data  = d;
  endtask

  initial begin
    rst_i        = 1'b1;
    start_i      = 1'b1;
    cpu_stall_i  = 1'b0;
    flush_i      = 1'b0;
    up_if.valid  = 1'b0;
    up_if.ctrl   = 8'h00;
    up_if.data   = 64'h0;
    dn_if.ready  = 1'b0;
    tick();
    tick();
    chk_out("reset", 1'b0, 8'h00, 64'h0, 2'd0, 1'b1);
    rst_i = 1'b0;

    // Streaming at full rate
    dn_if.ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      push(8'(8'h10 + i), 64'(i));
      tick();
      chk_out("stream", 1'b1, 8'(8'h10 + i), 64'(i), 2'd1, 1'b1);
    end
    up_if.valid = 1'b0;
    tick();
    chk_out("stream_drain", 1'b0, 8'h00, 64'h5, 2'd0, 1'b1);

    // Back-pressure fill, then drain in order
    dn_if.ready = 1'b0;
    push(8'hA1, 64'hA);
    tick();
    chk_out("bp_a", 1'b1, 8'hA1, 64'hA, 2'd1, 1'b1);
    push(8'hB2, 64'hB);
    tick();
    chk_out("bp_b", 1'b1, 8'hA1, 64'hA, 2'd2, 1'b0);
    push(8'hC3, 64'hC);
    tick();
    chk_out("bp_c_held", 1'b1, 8'hA1, 64'hA, 2'd2, 1'b0);
    dn_if.ready = 1'b1;
    tick();
    chk_out("bp_out_b", 1'b1, 8'hB2, 64'hB, 2'd1, 1'b1);
    tick();
    chk_out("bp_out_c", 1'b1, 8'hC3, 64'hC, 2'd1, 1'b1);
    up_if.valid = 1'b0;
    tick();
    chk_out("bp_empty", 1'b0, 8'h00, 64'hC, 2'd0, 1'b1);

    // Stall freeze while FULL
    dn_if.ready = 1'b0;
    push(8'hD4, 64'hD);
    tick();
    push(8'hE5, 64'hE);
    tick();
    up_if.valid = 1'b0;
    cpu_stall_i = 1'b1;
    dn_if.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("stall", 1'b1, 8'hD4, 64'hD, 2'd2, 1'b0);
    end
    cpu_stall_i = 1'b0;
    tick();
    chk_out("stall_rel_e", 1'b1, 8'hE5, 64'hE, 2'd1, 1'b1);
    tick();
    chk_out("stall_rel_empty", 1'b0, 8'h00, 64'hE, 2'd0, 1'b1);

    // Flush while FULL: bubble, payload kept
    dn_if.ready = 1'b0;
    push(8'hFF, 64'h55);
    tick();
    push(8'hFF, 64'h66);
    tick();
    chk_out("flush_pre", 1'b1, 8'hFF, 64'h55, 2'd2, 1'b0);
    up_if.valid = 1'b0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk_out("flush", 1'b0, 8'h00, 64'h55, 2'd0, 1'b1);

    // Flush with stall and a concurrent input: flush wins, input dropped
    push(8'h12, 64'h77);
    tick();
    chk_out("prio_pre", 1'b1, 8'h12, 64'h77, 2'd1, 1'b1);
    push(8'h13, 64'h88);
    flush_i     = 1'b1;
    cpu_stall_i = 1'b1;
    tick();
    flush_i     = 1'b0;
    cpu_stall_i = 1'b0;
    up_if.valid = 1'b0;
    chk_out("prio_flush", 1'b0, 8'h00, 64'h77, 2'd0, 1'b1);

    // start_i low blocks accept but not drain
    push(8'h21, 64'h91);
    tick();
    start_i = 1'b0;
    push(8'h22, 64'h92);
    tick();
    chk_out("start_hold", 1'b1, 8'h21, 64'h91, 2'd1, 1'b1);
    dn_if.ready = 1'b1;
    tick();
    chk_out("start_drain", 1'b0, 8'h00, 64'h91, 2'd0, 1'b1);
    tick();
    chk_out("start_block", 1'b0, 8'h00, 64'h91, 2'd0, 1'b1);
    start_i = 1'b1;
    tick();
    chk_out("start_resume", 1'b1, 8'h22, 64'h92, 2'd1, 1'b1);
    up_if.valid = 1'b0;
    tick();

    // Asynchronous reset mid-cycle while FULL
    dn_if.ready = 1'b0;
    push(8'h31, 64'hA0);
    tick();
    push(8'h32, 64'hB0);
    tick();
    up_if.valid = 1'b0;
    chk_out("arst_pre", 1'b1, 8'h31, 64'hA0, 2'd2, 1'b0);
    #2;
    rst_i = 1'b1;
    #1;
    chk_out("arst", 1'b0, 8'h00, 64'h0, 2'd0, 1'b1);
    rst_i = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
